arm_execute_stage: RTL and testbench

//  Execute stage directly downstream of the operand-2 shifter: takes SrcA plus the shifted operand
//  (ALUSrc2), evaluates the ARM condition against a registered NZCV flag file, performs the

---
 rtl/arm_execute_stage.sv | 150 +++++++++++++++
 tb/tb_arm_execute_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/arm_execute_stage.sv
// ARM data-processing execute stage: condition check against the registered NZCV flags,
// ALU op with flag update, and a single registered result slot using a valid/ready handshake.
module arm_execute_stage #(
   parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic [3:0]  alu_op,
   input  logic        set_flags,
   input  logic [3:0]  cond,
   input  logic [3:0]  rd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [3:0]  out_rd,
   output logic        out_write,
   output logic [3:0]  flags
);

   typedef enum logic [3:0] {
      OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
      OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
   } alu_op_e;

   typedef enum logic [3:0] {
      CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
      CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
   } cond_e;

   logic        valid_q, valid_d;
   logic [31:0] result_q, result_d;
   logic [3:0]  rd_q, rd_d;
   logic        write_q, write_d;
   logic [3:0]  flags_q, flags_d;

   alu_op_e     op;
   cond_e       cc;
   logic        fn, fz, fc, fv;
   logic        pass, is_test, is_arith, accept;
   logic [31:0] add_x, add_y, res;
   logic        add_cin;
   logic [32:0] sum;
   logic [3:0]  nzcv;

   assign op = alu_op_e'(alu_op);
   assign cc = cond_e'(cond);
   assign {fn, fz, fc, fv} = flags_q;

   always_comb begin
      pass = 1'b0;
      unique case (cc)
         CC_EQ: pass = fz;
         CC_NE: pass = !fz;
         CC_CS: pass = fc;
         CC_CC: pass = !fc;
         CC_MI: pass = fn;
         CC_PL: pass = !fn;
         CC_VS: pass = fv;
         CC_VC: pass = !fv;
         CC_HI: pass = fc & !fz;
         CC_LS: pass = !fc | fz;
         CC_GE: pass = (fn == fv);
         CC_LT: pass = (fn != fv);
         CC_GT: pass = !fz & (fn == fv);
         CC_LE: pass = fz | (fn != fv);
         CC_AL: pass = 1'b1;
         CC_NV: pass = 1'b0;
      endcase
   end

   // Every arithmetic op is folded onto one 33-bit adder: x + y + cin.
   always_comb begin
      add_x    = src_a;
      add_y    = src_b;
      add_cin  = 1'b0;
      is_arith = 1'b1;
      res      = '0;
      unique case (op)
         OP_ADD, OP_CMN: ;
         OP_ADC:         add_cin = fc;
         OP_SUB, OP_CMP: begin add_y = ~src_b; add_cin = 1'b1; end
         OP_SBC:         begin add_y = ~src_b; add_cin = fc;   end
         OP_RSB:         begin add_x = src_b; add_y = ~src_a; add_cin = 1'b1; end
         OP_RSC:         begin add_x = src_b; add_y = ~src_a; add_cin = fc;   end
         default:        is_arith = 1'b0;
      endcase
      sum = {1'b0, add_x} + {1'b0, add_y} + {32'b0, add_cin};
      unique case (op)
         OP_AND, OP_TST: res = src_a & src_b;
         OP_EOR, OP_TEQ: res = src_a ^ src_b;
         OP_ORR:         res = src_a | src_b;
         OP_MOV:         res = src_b;
         OP_BIC:         res = src_a & ~src_b;
         OP_MVN:         res = ~src_b;
         default:        res = sum[31:0];
      endcase
      nzcv[3] = res[31];
      nzcv[2] = (res == '0);
      nzcv[1] = is_arith ? sum[32] : fc;
      nzcv[0] = is_arith ? ((add_x[31] == add_y[31]) & (sum[31] != add_x[31])) : fv;
   end

   assign is_test  = op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
   assign in_ready = !valid_q | out_ready;
   assign accept   = in_valid & in_ready;

   always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      rd_d     = rd_q;
      write_d  = write_q;
      flags_d  = flags_q;
      if (accept) begin
         valid_d  = 1'b1;
         result_d = res;
         rd_d     = rd;
         write_d  = pass & !is_test;
         if (pass & (set_flags | is_test)) flags_d = nzcv;
      end else if (valid_q & out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
         write_q  <= 1'b0;
         flags_q  <= FLAGS_RESET;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         rd_q     <= rd_d;
         write_q  <= write_d;
         flags_q  <= flags_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_result = result_q;
   assign out_rd     = rd_q;
   assign out_write  = write_q;
   assign flags      = flags_q;

endmodule

// File: tb/tb_arm_execute_stage.sv
// Bench for arm_execute_stage: directed cases with known answers plus randomized traffic
// checked against a cycle model whose ALU is computed with 64-bit integer arithmetic.
module tb_arm_execute_stage;

   localparam logic [3:0] TB_FLAGS = 4'b0101;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, set_flags, out_valid, out_ready, out_write;
   logic [31:0] src_a, src_b, out_result;
   logic [3:0]  alu_op, cond, rd, out_rd, flags;

   always #5 clk = ~clk;

   arm_execute_stage #(.FLAGS_RESET(TB_FLAGS)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .src_a(src_a), .src_b(src_b), .alu_op(alu_op), .set_flags(set_flags),
      .cond(cond), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_rd(out_rd), .out_write(out_write), .flags(flags)
   );

   int errors = 0;
   int checks = 0;

   logic        m_valid = 1'b0, m_write = 1'b0;
   logic [31:0] m_res = '0;
   logic [3:0]  m_rd = '0, m_flags = TB_FLAGS;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Unsigned 64-bit result gives the carry, signed 64-bit result gives the overflow.
   function automatic void ref_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] fin, output logic [31:0] res, output logic [3:0] fout);
      logic [63:0] ua, ub, u, nb;
      longint      sa, sb, sv, snb;
      logic        carry, arith;
      ua = {32'b0, a};  ub = {32'b0, b};
      sa = $signed(a);  sb = $signed(b);
      nb = fin[1] ? 64'd0 : 64'd1;
      snb = fin[1] ? 0 : 1;
      arith = 1'b1; carry = 1'b0; sv = 0; u = '0;
      case (op)
         4'd4, 4'd11: begin u = ua + ub;      sv = sa + sb;       carry = u[32]; end
         4'd5:        begin u = ua + ub + {63'b0, fin[1]}; sv = sa + sb + (fin[1] ? 1 : 0); carry = u[32]; end
         4'd2, 4'd10: begin u = ua - ub;      sv = sa - sb;       carry = ua >= ub; end
         4'd6:        begin u = ua - ub - nb; sv = sa - sb - snb; carry = ua >= ub + nb; end
         4'd3:        begin u = ub - ua;      sv = sb - sa;       carry = ub >= ua; end
         4'd7:        begin u = ub - ua - nb; sv = sb - sa - snb; carry = ub >= ua + nb; end
         4'd0, 4'd8:  begin u = ua & ub;  arith = 1'b0; end
         4'd1, 4'd9:  begin u = ua ^ ub;  arith = 1'b0; end
         4'd12:       begin u = ua | ub;  arith = 1'b0; end
         4'd13:       begin u = ub;       arith = 1'b0; end
         4'd14:       begin u = ua & ~ub; arith = 1'b0; end
         default:     begin u = {32'b0, ~b}; arith = 1'b0; end
      endcase
      res  = u[31:0];
      fout = {res[31], res == 32'd0, arith ? carry : fin[1], arith ? (sv > SMAX || sv < SMIN) : fin[0]};
   endfunction

   task automatic drive(input logic rst, input logic v, input logic [3:0] op, input logic s,
                        input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] r, input logic ordy);
      reset = rst; in_valid = v; alu_op = op; set_flags = s; cond = c;
      src_a = a; src_b = b; rd = r; out_ready = ordy;
      #1;
      check("in_ready", {31'b0, in_ready}, {31'b0, !m_valid || ordy});
   endtask

   task automatic cycle();
      logic        nv, nw, acc, pass, test;
      logic [31:0] nres, r;
      logic [3:0]  nrd, nf, f;
      nv = m_valid; nw = m_write; nres = m_res; nrd = m_rd; nf = m_flags;
      acc = in_valid && (!m_valid || out_ready);
      if (reset) begin
         nv = 1'b0; nw = 1'b0; nres = '0; nrd = '0; nf = TB_FLAGS;
      end else if (acc) begin
         pass = cond_ok(cond, m_flags);
         test = alu_op >= 4'd8 && alu_op <= 4'd11;
         ref_exec(alu_op, src_a, src_b, m_flags, r, f);
         nv = 1'b1; nres = r; nrd = rd; nw = pass && !test;
         if (pass && (set_flags || test)) nf = f;
      end else if (m_valid && out_ready) begin
         nv = 1'b0;
      end
      @(posedge clk);
      #1;
      m_valid = nv; m_write = nw; m_res = nres; m_rd = nrd; m_flags = nf;
      check("out_valid",  {31'b0, out_valid}, {31'b0, m_valid});
      check("out_result", out_result, m_res);
      check("out_rd",     {28'b0, out_rd}, {28'b0, m_rd});
      check("out_write",  {31'b0, out_write}, {31'b0, m_write});
      check("flags",      {28'b0, flags}, {28'b0, m_flags});
   endtask

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      drive(1, 0, 4'd0, 0, 4'd14, 0, 0, 0, 1);
      cycle(); cycle();
      check("rst_flags", {28'b0, flags}, {28'b0, TB_FLAGS});
      check("rst_valid", {31'b0, out_valid}, 32'd0);

      drive(0, 1, 4'd4, 1, 4'd14, 32'h7FFF_FFFF, 32'd1, 4'd3, 1); cycle();
      check("add_ovf_res", out_result, 32'h8000_0000);
      check("add_ovf_wr",  {31'b0, out_write}, 32'd1);
      check("add_ovf_fl",  {28'b0, flags}, 32'h9);

      drive(0, 1, 4'd2, 1, 4'd14, 32'd5, 32'd5, 4'd1, 1); cycle();
      check("sub_eq_fl", {28'b0, flags}, 32'h6);
      drive(0, 1, 4'd4, 0, 4'd0, 32'd1, 32'd2, 4'd2, 1); cycle();
      check("add_eq_res", out_result, 32'd3);
      check("add_eq_wr",  {31'b0, out_write}, 32'd1);
      drive(0, 1, 4'd4, 0, 4'd1, 32'd1, 32'd2, 4'd2, 1); cycle();
      check("add_ne_wr",  {31'b0, out_write}, 32'd0);
      check("add_ne_vld", {31'b0, out_valid}, 32'd1);

      drive(0, 1, 4'd10, 0, 4'd14, 32'd3, 32'd7, 4'd4, 1); cycle();
      check("cmp_res", out_result, 32'hFFFF_FFFC);
      check("cmp_wr",  {31'b0, out_write}, 32'd0);
      check("cmp_fl",  {28'b0, flags}, 32'h8);
      drive(0, 1, 4'd6, 1, 4'd14, 32'd0, 32'd0, 4'd5, 1); cycle();
      check("sbc_res", out_result, 32'hFFFF_FFFF);
      check("sbc_fl",  {28'b0, flags}, 32'h8);

      drive(0, 1, 4'd10, 0, 4'd14, 32'd5, 32'd5, 4'd6, 1); cycle();
      drive(0, 1, 4'd5, 1, 4'd14, 32'hFFFF_FFFF, 32'd0, 4'd7, 1); cycle();
      check("adc_res", out_result, 32'd0);
      check("adc_fl",  {28'b0, flags}, 32'h6);

      drive(0, 1, 4'd4, 1, 4'd14, 32'd1, 32'd1, 4'd8, 1); cycle();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 4'd2, 1, 4'd14, 32'd1, 32'd2, 4'd9, 0); cycle();
         check("stall_res", out_result, 32'd2);
         check("stall_fl",  {28'b0, flags}, 32'h0);
      end
      drive(0, 1, 4'd2, 1, 4'd14, 32'd1, 32'd2, 4'd9, 1); cycle();
      check("release_res", out_result, 32'hFFFF_FFFF);
      check("release_fl",  {28'b0, flags}, 32'h8);
      drive(0, 0, 4'd0, 0, 4'd14, 0, 0, 0, 1); cycle();
      check("drain_vld", {31'b0, out_valid}, 32'd0);

      drive(0, 1, 4'd15, 1, 4'd14, 32'd0, 32'd0, 4'd10, 1); cycle();
      drive(0, 0, 4'd0, 0, 4'd14, 0, 0, 0, 0); cycle();
      drive(1, 1, 4'd4, 1, 4'd14, 32'd9, 32'd9, 4'd11, 0); cycle();
      check("rst_stall_vld", {31'b0, out_valid}, 32'd0);
      check("rst_stall_fl",  {28'b0, flags}, {28'b0, TB_FLAGS});

      for (int i = 0; i < 500; i++) begin
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), pick32(), pick32(),
               4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
